// File: rtl/traffic_light_ctrl.sv
// Single signal-head sequencer: RED -> GREEN -> YELLOW -> RED, timed in tick strobes,
// with a latched pedestrian request, flashing-yellow maintenance mode and remaining-time readout.
module traffic_light_ctrl #(
  parameter int RED_LEN    = 10,
  parameter int GREEN_LEN  = 10,
  parameter int YELLOW_LEN = 2,
  parameter int MIN_GREEN  = 4,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             btn,
  input  logic             flash_en,
  output logic [1:0]       lights,
  output logic             walk,
  output logic             ped_pending,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_FLASH  = 2'd3
  } state_t;

  localparam logic [1:0] LIGHTS_OFF    = 2'b00;
  localparam logic [1:0] LIGHTS_RED    = 2'b01;
  localparam logic [1:0] LIGHTS_GREEN  = 2'b10;
  localparam logic [1:0] LIGHTS_YELLOW = 2'b11;

  localparam int MAX_LEN = (RED_LEN > GREEN_LEN) ?
                           ((RED_LEN > YELLOW_LEN) ? RED_LEN : YELLOW_LEN) :
                           ((GREEN_LEN > YELLOW_LEN) ? GREEN_LEN : YELLOW_LEN);

  if (RED_LEN < 1 || GREEN_LEN < 1 || YELLOW_LEN < 1 ||
      MIN_GREEN < 1 || MIN_GREEN > GREEN_LEN ||
      CNT_W < 1 || CNT_W > 30 || (MAX_LEN - 1) >= (1 << CNT_W)) begin : g_param_check
    $error("traffic_light_ctrl: illegal parameter configuration");
  end

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_LEN - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_LEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_LEN - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic [1:0]       lights_reg, lights_next;
  logic             walk_reg, walk_next;
  logic             pending_reg, pending_next;
  logic [1:0]       sync_reg;
  logic             btn_prev_reg;
  logic             btn_edge;
  logic [CNT_W-1:0] phase_last;
  logic             enter_red;

  // Two-flop synchroniser plus one history flop for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg     <= 2'b00;
      btn_prev_reg <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[0], btn};
      btn_prev_reg <= sync_reg[1];
    end
  end

  assign btn_edge = sync_reg[1] & ~btn_prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_RED;
      timer_reg   <= '0;
      lights_reg  <= LIGHTS_RED;
      walk_reg    <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      lights_reg  <= lights_next;
      walk_reg    <= walk_next;
      pending_reg <= pending_next;
    end
  end

  always_comb begin
    phase_last = '0;
    case (state_reg)
      S_RED:    phase_last = RED_LAST;
      S_GREEN:  phase_last = GREEN_LAST;
      S_YELLOW: phase_last = YELLOW_LAST;
      default:  phase_last = '0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    lights_next  = lights_reg;
    walk_next    = walk_reg;
    pending_next = pending_reg | btn_edge;
    enter_red    = 1'b0;

    if (tick) begin
      if (flash_en) begin
        state_next  = S_FLASH;
        timer_next  = '0;
        walk_next   = 1'b0;
        lights_next = (state_reg == S_FLASH && lights_reg == LIGHTS_YELLOW) ?
                      LIGHTS_OFF : LIGHTS_YELLOW;
      end else begin
        case (state_reg)
          S_RED: begin
            if (timer_reg == RED_LAST) begin
              state_next  = S_GREEN;
              timer_next  = '0;
              lights_next = LIGHTS_GREEN;
              walk_next   = 1'b0;
            end else begin
              timer_next = timer_reg + TIMER_ONE;
            end
          end
          S_GREEN: begin
            // The registered request decides shortening, so a request latched this cycle waits a tick.
            if (timer_reg == GREEN_LAST || (pending_reg && timer_reg >= MIN_LAST)) begin
              state_next  = S_YELLOW;
              timer_next  = '0;
              lights_next = LIGHTS_YELLOW;
            end else begin
              timer_next = timer_reg + TIMER_ONE;
            end
          end
          S_YELLOW: begin
            if (timer_reg == YELLOW_LAST) begin
              enter_red = 1'b1;
            end else begin
              timer_next = timer_reg + TIMER_ONE;
            end
          end
          default: begin
            enter_red = 1'b1;
          end
        endcase
      end

      // Serving the old request on RED entry; a fresh edge this cycle stays pending for the next RED.
      if (enter_red) begin
        state_next   = S_RED;
        timer_next   = '0;
        lights_next  = LIGHTS_RED;
        walk_next    = pending_reg;
        pending_next = btn_edge;
      end
    end
  end

  assign lights      = lights_reg;
  assign walk        = walk_reg;
  assign ped_pending = pending_reg;
  assign remaining   = (state_reg == S_FLASH) ? '0 : (phase_last - timer_reg);

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with default parameters; expected values are hand-derived
// from the phase lengths (RED 10, GREEN 10, YELLOW 2, MIN_GREEN 4).
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       btn = 1'b0;
  logic       flash_en = 1'b0;
  logic [1:0] lights;
  logic       walk;
  logic       ped_pending;
  logic [4:0] remaining;

  int n_checks = 0;
  int n_errors = 0;
  int n_ticks  = 0;

  traffic_light_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .btn         (btn),
    .flash_en    (flash_en),
    .lights      (lights),
    .walk        (walk),
    .ped_pending (ped_pending),
    .remaining   (remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; leaves time at posedge+1 after the tick has been registered.
  task automatic do_tick();
    repeat (2) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    n_ticks++;
    $display("tick %0d: lights=%b walk=%b ped=%b rem=%0d", n_ticks, lights, walk, ped_pending, remaining);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pulse_btn();
    btn = 1'b1;
    repeat (4) @(posedge clk);
    #1 btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] l, input logic w,
                           input logic p, input logic [4:0] r);
    check({tag, ".lights"}, 32'(lights), 32'(l));
    check({tag, ".walk"}, 32'(walk), 32'(w));
    check({tag, ".ped"}, 32'(ped_pending), 32'(p));
    check({tag, ".rem"}, 32'(remaining), 32'(r));
  endtask

  initial begin
    logic [1:0] exp_l;
    logic [4:0] exp_r;

    // Reset state, observed before any clock edge
    #1 reset = 1'b1;
    #1 check_all("reset", 2'b01, 1'b0, 1'b0, 5'd9);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Plain cycle without requests
    for (int k = 0; k < 22; k++) begin
      if (k < 10) begin
        exp_l = 2'b01; exp_r = 5'(9 - k);
      end else if (k < 20) begin
        exp_l = 2'b10; exp_r = 5'(19 - k);
      end else begin
        exp_l = 2'b11; exp_r = 5'(21 - k);
      end
      check($sformatf("cycle%0d.lights", k), 32'(lights), 32'(exp_l));
      check($sformatf("cycle%0d.rem", k), 32'(remaining), 32'(exp_r));
      check($sformatf("cycle%0d.walk", k), 32'(walk), 32'd0);
      do_tick();
    end
    check_all("cycle_end", 2'b01, 1'b0, 1'b0, 5'd9);

    // Pulse at GREEN timer=1 shortens GREEN at timer=3
    tick_n(11);
    check_all("s2_g1", 2'b10, 1'b0, 1'b0, 5'd8);
    pulse_btn();
    check_all("s2_pend", 2'b10, 1'b0, 1'b1, 5'd8);
    do_tick();
    check_all("s2_g2", 2'b10, 1'b0, 1'b1, 5'd7);
    do_tick();
    check_all("s2_g3", 2'b10, 1'b0, 1'b1, 5'd6);
    do_tick();
    check_all("s2_yel", 2'b11, 1'b0, 1'b1, 5'd1);
    tick_n(2);
    check_all("s2_red", 2'b01, 1'b1, 1'b0, 5'd9);
    tick_n(9);
    check_all("s2_red9", 2'b01, 1'b1, 1'b0, 5'd0);
    do_tick();
    check_all("s2_green", 2'b10, 1'b0, 1'b0, 5'd9);

    // Held button at GREEN timer=7 gives a single request
    tick_n(7);
    check_all("s3_g7", 2'b10, 1'b0, 1'b0, 5'd2);
    btn = 1'b1;
    repeat (50) @(posedge clk);
    #1 check_all("s3_held", 2'b10, 1'b0, 1'b1, 5'd2);
    do_tick();
    check_all("s3_yel", 2'b11, 1'b0, 1'b1, 5'd1);
    tick_n(2);
    check_all("s3_red", 2'b01, 1'b1, 1'b0, 5'd9);
    btn = 1'b0;
    repeat (5) @(posedge clk);
    #1 check_all("s3_rel", 2'b01, 1'b1, 1'b0, 5'd9);
    tick_n(10);
    check_all("s3_green", 2'b10, 1'b0, 1'b0, 5'd9);
    tick_n(4);
    check_all("s3_g4", 2'b10, 1'b0, 1'b0, 5'd5);
    tick_n(6);
    check_all("s3_yel2", 2'b11, 1'b0, 1'b0, 5'd1);
    tick_n(2);
    check_all("s3_red2", 2'b01, 1'b0, 1'b0, 5'd9);

    // Request during RED waits for the following RED
    tick_n(5);
    pulse_btn();
    check_all("s4_r5", 2'b01, 1'b0, 1'b1, 5'd4);
    tick_n(5);
    check_all("s4_green", 2'b10, 1'b0, 1'b1, 5'd9);
    tick_n(3);
    check_all("s4_g3", 2'b10, 1'b0, 1'b1, 5'd6);
    do_tick();
    check_all("s4_yel", 2'b11, 1'b0, 1'b1, 5'd1);
    tick_n(2);
    check_all("s4_red", 2'b01, 1'b1, 1'b0, 5'd9);

    // Flash mode entered from GREEN timer=6, request latched in FLASH served on exit
    tick_n(10);
    check_all("s5_green", 2'b10, 1'b0, 1'b0, 5'd9);
    tick_n(6);
    check_all("s5_g6", 2'b10, 1'b0, 1'b0, 5'd3);
    flash_en = 1'b1;
    do_tick();
    check_all("s5_f1", 2'b11, 1'b0, 1'b0, 5'd0);
    do_tick();
    check_all("s5_f2", 2'b00, 1'b0, 1'b0, 5'd0);
    pulse_btn();
    check_all("s5_fpend", 2'b00, 1'b0, 1'b1, 5'd0);
    do_tick();
    check_all("s5_f3", 2'b11, 1'b0, 1'b1, 5'd0);
    do_tick();
    check_all("s5_f4", 2'b00, 1'b0, 1'b1, 5'd0);
    flash_en = 1'b0;
    do_tick();
    check_all("s5_exit", 2'b01, 1'b1, 1'b0, 5'd9);

    // Asynchronous reset during YELLOW with a pending request
    tick_n(10);
    check_all("s6_green", 2'b10, 1'b0, 1'b0, 5'd9);
    tick_n(10);
    pulse_btn();
    check_all("s6_yel", 2'b11, 1'b0, 1'b1, 5'd1);
    reset = 1'b1;
    #1 check_all("s6_rst", 2'b01, 1'b0, 1'b0, 5'd9);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 check_all("s6_rel", 2'b01, 1'b0, 1'b0, 5'd9);
    tick_n(10);
    check_all("s6_g0", 2'b10, 1'b0, 1'b0, 5'd9);
    tick_n(4);
    check_all("s6_g4", 2'b10, 1'b0, 1'b0, 5'd5);
    tick_n(6);
    check_all("s6_y0", 2'b11, 1'b0, 1'b0, 5'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
